// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package instruction_fetch_pkg;

    localparam int OFFSET_W = 8;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en && (q_q != {W{1'b1}})) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/instruction_fetch.sv
// Program counter and fetch sequencing for the 9-bit core: drives the synchronous
// instruction ROM, tracks run state and keeps cycle / retired-instruction counters.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int PC_W   = 10,
    parameter int INST_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [PC_W-1:0]     start_addr,
    input  logic                stall,
    input  logic                halt,
    input  logic                ctrl_branch,
    input  logic                take_branch,
    input  logic [OFFSET_W-1:0] branch_offset,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INST_W-1:0]   imem_data,
    output logic [INST_W-1:0]   instruction,
    output logic                instr_valid,
    output logic [PC_W-1:0]     pc,
    output logic                done,
    output logic                pc_overflow,
    output logic [CNT_W-1:0]    cycle_count,
    output logic [CNT_W-1:0]    inst_count
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            pc_overflow_q, pc_overflow_d;

    logic            running;
    logic            retire;
    logic            branch_taken;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] target;

    assign running      = (state_q == FETCH_RUN);
    assign retire       = running && !stall;
    assign branch_taken = ctrl_branch && take_branch;
    assign pc_plus1     = pc_q + PC_W'(1);
    // Branch wrap is legal: the sum is simply truncated to PC_W bits.
    assign target       = pc_q + {{(PC_W-OFFSET_W){branch_offset[OFFSET_W-1]}}, branch_offset};

    // A restart always pre-fetches start_addr so the first instruction is live next cycle.
    always_comb begin
        imem_addr = start_addr;
        if (running && !start) begin
            if (stall || halt) begin
                imem_addr = pc_q;
            end else if (branch_taken) begin
                imem_addr = target;
            end else begin
                imem_addr = pc_plus1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_overflow_d = pc_overflow_q;
        if (start) begin
            state_d       = FETCH_RUN;
            pc_d          = start_addr;
            pc_overflow_d = 1'b0;
        end else if (retire) begin
            if (halt) begin
                state_d = FETCH_DONE;
            end else if (!branch_taken && (pc_q == {PC_W{1'b1}})) begin
                state_d       = FETCH_DONE;
                pc_overflow_d = 1'b1;
            end else begin
                pc_d = imem_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH_IDLE;
            pc_q          <= '0;
            pc_overflow_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_overflow_q <= pc_overflow_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (running),
        .clr   (start),
        .q     (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_inst_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (retire),
        .clr   (start),
        .q     (inst_count)
    );

    assign instruction = imem_data;
    assign instr_valid = running;
    assign done        = (state_q == FETCH_DONE);
    assign pc          = pc_q;
    assign pc_overflow = pc_overflow_q;

endmodule
